base_linear_classifier: RTL and testbench

- Upstream base learner for the stacking ensemble. Three instances feed the logistic combiner's inPredict1..3 / ready1..3 inputs.
- Streams one feature vector of N_FEAT signed samples and computes a weighted dot product against a loadable weight RAM. Adds a bias and compares the sum against a threshold.
- Emits a ±1 prediction (2'b01 / 2'b11) with a level `ready` that holds until the consumer acknowledges it.

---
 rtl/base_linear_classifier.sv | 169 ++++++++++++++++
 tb/tb_base_linear_classifier.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/base_linear_classifier.sv
// -----------------------------------------------------------------------------
// base_linear_classifier
//
// Upstream base learner for the stacking ensemble. It streams one feature
// vector of N_FEAT signed samples, accumulates the dot product against a
// loadable weight RAM, adds a bias and compares the result against a
// threshold. The +1/-1 decision is presented with a level 'ready' that stays
// up until the consumer acknowledges it.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous, active-low reset
//   wt_we      - weight write strobe (honoured in any state)
//   wt_addr    - weight index; indices >= N_FEAT are ignored
//   wt_data    - signed weight value
//   bias       - signed bias, static while a vector is in flight
//   thred      - signed decision threshold, static while a vector is in flight
//   feat_valid - feature sample valid
//   feat_data  - signed feature sample
//   feat_ready - block accepts a sample this cycle (registered)
//   ready      - prediction valid, held until pred_ack
//   predict    - 2'b01 = +1, 2'b11 = -1, 2'b00 after reset
//   pred_ack   - consumer has taken the prediction
// -----------------------------------------------------------------------------
module base_linear_classifier #(
    parameter int N_FEAT = 4,
    parameter int FEAT_W = 8,
    parameter int WT_W   = 10,
    localparam int AW    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wt_we,
    input  logic [AW-1:0]            wt_addr,
    input  logic signed [WT_W-1:0]   wt_data,
    input  logic signed [WT_W-1:0]   bias,
    input  logic signed [WT_W-1:0]   thred,
    input  logic                     feat_valid,
    input  logic signed [FEAT_W-1:0] feat_data,
    output logic                     feat_ready,
    output logic                     ready,
    output logic [1:0]               predict,
    input  logic                     pred_ack
);

    localparam int PROD_W = FEAT_W + WT_W;
    localparam int ACC_W  = PROD_W + AW + 1;
    localparam logic [AW-1:0] CNT_LAST = AW'(N_FEAT - 1);

    localparam logic [1:0] PRED_POS = 2'b01;
    localparam logic [1:0] PRED_NEG = 2'b11;

    typedef enum logic [1:0] {
        ACCUM,
        CMP,
        HOLD
    } state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic                     ready_q, ready_d;
    logic [1:0]               predict_q, predict_d;
    logic                     featReady_q, featReady_d;

    logic signed [WT_W-1:0]   weight_q [N_FEAT];

    logic                     addrOk;
    logic signed [WT_W-1:0]   wtRd;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  thredExt;

    // An out-of-range write index only exists when N_FEAT is not a power of two.
    if ((1 << AW) == N_FEAT) begin : gAddrFull
        assign addrOk = 1'b1;
    end else begin : gAddrPart
        assign addrOk = (wt_addr < AW'(N_FEAT));
    end

    // Weight RAM as a register file. The datapath reads the registered value,
    // so a same-cycle write to the index being used still contributes the old
    // weight and the new one becomes visible on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_FEAT; i++) begin
                weight_q[i] <= '0;
            end
        end else if (wt_we && addrOk) begin
            weight_q[wt_addr] <= wt_data;
        end
    end

    // Datapath: full-precision product, and the biased sum versus threshold
    // with both operands sign-extended to the accumulator width.
    assign wtRd     = weight_q[cnt_q];
    assign prod     = PROD_W'(feat_data) * PROD_W'(wtRd);
    assign sum      = acc_q + ACC_W'(bias);
    assign thredExt = ACC_W'(thred);

    // State and datapath registers. Reset discards any partial vector and drops
    // ready at once; feat_ready comes out of reset high so a vector can start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            predict_q   <= 2'b00;
            featReady_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            predict_q   <= predict_d;
            featReady_q <= featReady_d;
        end
    end

    // Next-state logic. ACCUM takes samples (bubbles simply hold everything),
    // CMP makes the decision in one cycle (ties go to -1), HOLD waits for the
    // acknowledge and then clears the accumulator for the next vector while
    // leaving the last decision on predict.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        predict_d   = predict_q;
        featReady_d = featReady_q;

        unique case (state_q)
            ACCUM: begin
                if (feat_valid && featReady_q) begin
                    acc_d = acc_q + ACC_W'(prod);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d       = '0;
                        state_d     = CMP;
                        featReady_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CMP: begin
                predict_d = (sum > thredExt) ? PRED_POS : PRED_NEG;
                ready_d   = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (pred_ack) begin
                    ready_d     = 1'b0;
                    acc_d       = '0;
                    featReady_d = 1'b1;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    assign feat_ready = featReady_q;
    assign ready      = ready_q;
    assign predict    = predict_q;

endmodule

// File: tb/tb_base_linear_classifier.sv
// -----------------------------------------------------------------------------
// tb_base_linear_classifier
//
// Directed bench for base_linear_classifier with N_FEAT=4, FEAT_W=8, WT_W=10.
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, so nothing is sampled on the active edge.
// -----------------------------------------------------------------------------
module tb_base_linear_classifier;

    localparam int N_FEAT = 4;
    localparam int FEAT_W = 8;
    localparam int WT_W   = 10;
    localparam int AW     = $clog2(N_FEAT);

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     wt_we = 1'b0;
    logic [AW-1:0]            wt_addr = '0;
    logic signed [WT_W-1:0]   wt_data = '0;
    logic signed [WT_W-1:0]   bias = '0;
    logic signed [WT_W-1:0]   thred = '0;
    logic                     feat_valid = 1'b0;
    logic signed [FEAT_W-1:0] feat_data = '0;
    logic                     feat_ready;
    logic                     ready;
    logic [1:0]               predict;
    logic                     pred_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    base_linear_classifier #(
        .N_FEAT(N_FEAT),
        .FEAT_W(FEAT_W),
        .WT_W  (WT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wt_we     (wt_we),
        .wt_addr   (wt_addr),
        .wt_data   (wt_data),
        .bias      (bias),
        .thred     (thred),
        .feat_valid(feat_valid),
        .feat_data (feat_data),
        .feat_ready(feat_ready),
        .ready     (ready),
        .predict   (predict),
        .pred_ack  (pred_ack)
    );

    // 10 time-unit clock period.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if something wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic writeWeight(input int addr, input int val);
        wt_we   = 1'b1;
        wt_addr = AW'(addr);
        wt_data = WT_W'(val);
        tick();
        wt_we   = 1'b0;
    endtask

    task automatic loadWeights(input int w0, input int w1, input int w2, input int w3);
        writeWeight(0, w0);
        writeWeight(1, w1);
        writeWeight(2, w2);
        writeWeight(3, w3);
    endtask

    task automatic applyStimulus(input logic valid, input int data);
        feat_valid = valid;
        feat_data  = FEAT_W'(data);
        tick();
        feat_valid = 1'b0;
    endtask

    // One full vector: four back-to-back samples, decision timing, optional
    // ack hold window, then the ack itself. colWe writes W[0] in the same
    // cycle the first sample is accepted.
    task automatic runVector(input string tag, input int f0, input int f1,
                             input int f2, input int f3, input int b, input int t,
                             input logic [1:0] expPred, input int holdCycles,
                             input logic colWe, input int colData);
        int   f [4];
        logic stable;
        f     = '{f0, f1, f2, f3};
        bias  = WT_W'(b);
        thred = WT_W'(t);
        for (int i = 0; i < 4; i++) begin
            if (i == 0 && colWe) begin
                wt_we   = 1'b1;
                wt_addr = '0;
                wt_data = WT_W'(colData);
            end
            applyStimulus(1'b1, f[i]);
            wt_we = 1'b0;
        end
        checkOutput({tag, ":featReadyLow"}, 32'(feat_ready), 32'd0);
        checkOutput({tag, ":readyNotYet"}, 32'(ready), 32'd0);
        tick();
        checkOutput({tag, ":readyRise"}, 32'(ready), 32'd1);
        checkOutput({tag, ":predict"}, 32'(predict), 32'(expPred));
        stable = 1'b1;
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            if (ready !== 1'b1 || predict !== expPred || feat_ready !== 1'b0) stable = 1'b0;
        end
        if (holdCycles > 0) checkOutput({tag, ":holdStable"}, 32'(stable), 32'd1);
        pred_ack = 1'b1;
        tick();
        pred_ack = 1'b0;
        checkOutput({tag, ":ackReady"}, 32'(ready), 32'd0);
        checkOutput({tag, ":ackFeatReady"}, 32'(feat_ready), 32'd1);
        checkOutput({tag, ":predictKept"}, 32'(predict), 32'(expPred));
    endtask

    // Directed sequence covering reset, decisions, ties, width extremes,
    // bubbles, ack handshake, weight write collision and mid-flight resets.
    initial begin
        $display("[TB] start");
        rst = 1'b0;
        tick();
        tick();
        checkOutput("reset:ready", 32'(ready), 32'd0);
        checkOutput("reset:predict", 32'(predict), 32'd0);
        checkOutput("reset:featReady", 32'(feat_ready), 32'd1);
        rst = 1'b1;
        tick();

        // Positive decision: sum 10 > 5, with a 20-cycle ack hold.
        loadWeights(1, 2, 3, 4);
        runVector("pos", 1, 1, 1, 1, 0, 5, 2'b01, 20, 1'b0, 0);

        // Tie, then +1 (also shows acc cleared), then -1.
        loadWeights(-3, 0, 0, 0);
        runVector("tie", 2, 0, 0, 0, 6, 0, 2'b11, 0, 1'b0, 0);
        runVector("bias7", 2, 0, 0, 0, 7, 0, 2'b01, 0, 1'b0, 0);
        runVector("bias5", 2, 0, 0, 0, 5, 0, 2'b11, 0, 1'b0, 0);

        // Width extremes with bubbles: each accept adds 65536.
        loadWeights(-512, -512, -512, -512);
        bias  = '0;
        thred = 10'sd511;
        applyStimulus(1'b1, -128);
        checkOutput("ext:acc1", 32'(dut.acc_q), 32'd65536);
        applyStimulus(1'b0, -128);
        applyStimulus(1'b0, -128);
        checkOutput("ext:accHold", 32'(dut.acc_q), 32'd65536);
        checkOutput("ext:cntHold", 32'(dut.cnt_q), 32'd1);
        applyStimulus(1'b1, -128);
        applyStimulus(1'b0, -128);
        checkOutput("ext:accHold2", 32'(dut.acc_q), 32'd131072);
        applyStimulus(1'b1, -128);
        applyStimulus(1'b0, -128);
        applyStimulus(1'b0, -128);
        applyStimulus(1'b0, -128);
        checkOutput("ext:cnt3", 32'(dut.cnt_q), 32'd3);
        applyStimulus(1'b1, -128);
        checkOutput("ext:accFull", 32'(dut.acc_q), 32'd262144);
        checkOutput("ext:featReadyLow", 32'(feat_ready), 32'd0);
        tick();
        checkOutput("ext:ready", 32'(ready), 32'd1);
        checkOutput("ext:predict", 32'(predict), 32'd1);
        pred_ack = 1'b1;
        tick();
        pred_ack = 1'b0;
        checkOutput("ext:ackReady", 32'(ready), 32'd0);

        // Weight write collides with the accept of sample 0: old weight 2 is
        // used (sum 2, not > 3), next vector sees 5 (sum 5 > 3).
        loadWeights(2, 0, 0, 0);
        runVector("colOld", 1, 0, 0, 0, 0, 3, 2'b11, 0, 1'b1, 5);
        runVector("colNew", 1, 0, 0, 0, 0, 3, 2'b01, 0, 1'b0, 0);

        // Reset while holding a result: ready and predict fall without a clock.
        loadWeights(5, 0, 0, 0);
        bias  = '0;
        thred = '0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1);
        tick();
        checkOutput("hold:readyBefore", 32'(ready), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("hold:rstReady", 32'(ready), 32'd0);
        checkOutput("hold:rstPredict", 32'(predict), 32'd0);
        rst = 1'b1;
        tick();

        // Reset after two of four samples.
        loadWeights(5, 0, 0, 0);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b1, 1);
        rst = 1'b0;
        #1;
        checkOutput("mid:rstReady", 32'(ready), 32'd0);
        checkOutput("mid:rstFeatReady", 32'(feat_ready), 32'd1);
        checkOutput("mid:rstAcc", 32'(dut.acc_q), 32'd0);
        checkOutput("mid:rstCnt", 32'(dut.cnt_q), 32'd0);
        rst = 1'b1;
        tick();

        // Weights were cleared: sum 0 ties thred 0 -> -1.
        runVector("cleared", 1, 1, 1, 1, 0, 0, 2'b11, 0, 1'b0, 0);
        // Reloaded weights: sum 10 > 9 -> +1.
        loadWeights(1, 2, 3, 4);
        runVector("reload", 1, 1, 1, 1, 0, 9, 2'b01, 0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
